// File: rtl/butterfly_r2.sv
// Radix-2 DIT butterfly: X1 = A + W*B, X2 = A - W*B, with optional /2 rounding and saturation.
// Latency 3 cycles, one operand set per cycle, never stalls.
module butterfly_r2 #(
  parameter int bit_width = 16,
  parameter int TW_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic                        scale,
  input  logic signed [bit_width-1:0] Re_a,
  input  logic signed [bit_width-1:0] Im_a,
  input  logic signed [bit_width-1:0] Re_b,
  input  logic signed [bit_width-1:0] Im_b,
  input  logic signed [TW_WIDTH-1:0]  Re_w,
  input  logic signed [TW_WIDTH-1:0]  Im_w,
  input  logic                        clr_ovf,
  output logic signed [bit_width-1:0] Re_o_1,
  output logic signed [bit_width-1:0] Im_o_1,
  output logic signed [bit_width-1:0] Re_o_2,
  output logic signed [bit_width-1:0] Im_o_2,
  output logic                        out_valid,
  output logic                        ovf
);

  localparam int PW   = bit_width + TW_WIDTH;
  localparam int SW   = PW + 1;
  localparam int TT   = bit_width + 2;
  localparam int AW   = bit_width + 3;
  localparam int FRAC = TW_WIDTH - 2;

  localparam logic signed [SW-1:0] RND     = SW'(2 ** (FRAC - 1));
  localparam logic signed [AW-1:0] SAT_MAX = AW'(2 ** (bit_width - 1) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = -SAT_MAX - AW'(1);

  // Stage 1: full-width products, A/scale/valid aligned alongside
  logic signed [PW-1:0]        w_p_rr, w_p_ii, w_p_ri, w_p_ir;
  logic signed [PW-1:0]        r1_p_rr, r1_p_ii, r1_p_ri, r1_p_ir;
  logic signed [bit_width-1:0] r1_re_a, r1_im_a;
  logic                        r1_scale, r1_vld;

  assign w_p_rr = PW'(Re_b) * PW'(Re_w);
  assign w_p_ii = PW'(Im_b) * PW'(Im_w);
  assign w_p_ri = PW'(Re_b) * PW'(Im_w);
  assign w_p_ir = PW'(Im_b) * PW'(Re_w);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_p_rr  <= '0;
      r1_p_ii  <= '0;
      r1_p_ri  <= '0;
      r1_p_ir  <= '0;
      r1_re_a  <= '0;
      r1_im_a  <= '0;
      r1_scale <= 1'b0;
      r1_vld   <= 1'b0;
    end else begin
      r1_p_rr  <= w_p_rr;
      r1_p_ii  <= w_p_ii;
      r1_p_ri  <= w_p_ri;
      r1_p_ir  <= w_p_ir;
      r1_re_a  <= Re_a;
      r1_im_a  <= Im_a;
      r1_scale <= scale;
      r1_vld   <= in_valid;
    end
  end

  // Stage 2: complex multiply, round half-up back to sample scale.
  // t keeps one bit beyond the unit-twiddle range so non-unit W cannot wrap.
  logic signed [SW-1:0]        w_t_re_full, w_t_im_full;
  logic signed [TT-1:0]        r2_t_re, r2_t_im;
  logic signed [bit_width-1:0] r2_re_a, r2_im_a;
  logic                        r2_scale, r2_vld;

  assign w_t_re_full = SW'(r1_p_rr) - SW'(r1_p_ii) + RND;
  assign w_t_im_full = SW'(r1_p_ri) + SW'(r1_p_ir) + RND;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_t_re  <= '0;
      r2_t_im  <= '0;
      r2_re_a  <= '0;
      r2_im_a  <= '0;
      r2_scale <= 1'b0;
      r2_vld   <= 1'b0;
    end else begin
      r2_t_re  <= TT'(w_t_re_full >>> FRAC);
      r2_t_im  <= TT'(w_t_im_full >>> FRAC);
      r2_re_a  <= r1_re_a;
      r2_im_a  <= r1_im_a;
      r2_scale <= r1_scale;
      r2_vld   <= r1_vld;
    end
  end

  // Stage 3: add/subtract, optional rounded halving, saturate
  logic signed [AW-1:0]        w_sum [4];
  logic signed [AW-1:0]        w_scl [4];
  logic signed [bit_width-1:0] w_res [4];
  logic [3:0]                  w_sat;

  always_comb begin
    w_sum[0] = AW'(r2_re_a) + AW'(r2_t_re);
    w_sum[1] = AW'(r2_im_a) + AW'(r2_t_im);
    w_sum[2] = AW'(r2_re_a) - AW'(r2_t_re);
    w_sum[3] = AW'(r2_im_a) - AW'(r2_t_im);
    for (int i = 0; i < 4; i++) begin
      w_scl[i] = r2_scale ? ((w_sum[i] + AW'(1)) >>> 1) : w_sum[i];
      w_sat[i] = 1'b0;
      w_res[i] = w_scl[i][bit_width-1:0];
      if (w_scl[i] > SAT_MAX) begin
        w_sat[i] = 1'b1;
        w_res[i] = SAT_MAX[bit_width-1:0];
      end else if (w_scl[i] < SAT_MIN) begin
        w_sat[i] = 1'b1;
        w_res[i] = SAT_MIN[bit_width-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Re_o_1    <= '0;
      Im_o_1    <= '0;
      Re_o_2    <= '0;
      Im_o_2    <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      Re_o_1    <= w_res[0];
      Im_o_1    <= w_res[1];
      Re_o_2    <= w_res[2];
      Im_o_2    <= w_res[3];
      out_valid <= r2_vld;
      // a new saturation outranks a simultaneous clear
      ovf       <= (ovf & ~clr_ovf) | (r2_vld & (|w_sat));
    end
  end

endmodule

// File: tb/tb_butterfly_r2.sv
// Bench for butterfly_r2: directed vector table, multi-cycle corner sequences, random stream vs arithmetic model.
module tb_butterfly_r2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_valid, scale, clr_ovf;
  logic signed [15:0] Re_a, Im_a, Re_b, Im_b, Re_w, Im_w;
  logic signed [15:0] Re_o_1, Im_o_1, Re_o_2, Im_o_2;
  logic out_valid, ovf;

  int checks = 0;
  int failures = 0;

  butterfly_r2 #(.bit_width(16), .TW_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .scale(scale),
    .Re_a(Re_a), .Im_a(Im_a), .Re_b(Re_b), .Im_b(Im_b),
    .Re_w(Re_w), .Im_w(Im_w), .clr_ovf(clr_ovf),
    .Re_o_1(Re_o_1), .Im_o_1(Im_o_1), .Re_o_2(Re_o_2), .Im_o_2(Im_o_2),
    .out_valid(out_valid), .ovf(ovf)
  );

  typedef struct {
    int ar, ai, br, bi, wr, wi;
    bit sc;
    int x1r, x1i, x2r, x2i;
    bit sat;
  } vec_t;

  typedef struct {
    int x1r, x1i, x2r, x2i;
    bit sat;
  } res_t;

  typedef struct {
    bit   v;
    res_t r;
  } pend_t;

  vec_t  tbl [11];
  pend_t q [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic res_t model(input int ar, ai, br, bi, wr, wi, input bit sc);
    res_t   r;
    longint tr, ti;
    longint s [4];
    tr = (longint'(br) * longint'(wr) - longint'(bi) * longint'(wi) + 8192) >>> 14;
    ti = (longint'(br) * longint'(wi) + longint'(bi) * longint'(wr) + 8192) >>> 14;
    s[0] = ar + tr;
    s[1] = ai + ti;
    s[2] = ar - tr;
    s[3] = ai - ti;
    r.sat = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (sc) s[k] = (s[k] + 1) >>> 1;
      if (s[k] > 32767) begin
        s[k] = 32767;
        r.sat = 1'b1;
      end else if (s[k] < -32768) begin
        s[k] = -32768;
        r.sat = 1'b1;
      end
    end
    r.x1r = int'(s[0]);
    r.x1i = int'(s[1]);
    r.x2r = int'(s[2]);
    r.x2i = int'(s[3]);
    return r;
  endfunction

  function automatic int rnd16();
    logic signed [15:0] x;
    x = 16'($urandom);
    return int'(x);
  endfunction

  task automatic drive(input int ar, ai, br, bi, wr, wi, input bit sc, input bit v);
    Re_a = 16'(ar);
    Im_a = 16'(ai);
    Re_b = 16'(br);
    Im_b = 16'(bi);
    Re_w = 16'(wr);
    Im_w = 16'(wi);
    scale = sc;
    in_valid = v;
  endtask

  task automatic clear_ovf();
    @(posedge clk); #1 clr_ovf = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1 clr_ovf = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", int'(ovf), 0);
  endtask

  // single pulse; measures latency within a bounded window, then checks data and the one-cycle valid
  task automatic run_one(input vec_t t, input string tag);
    int lat;
    lat = 0;
    @(posedge clk); #1 drive(t.ar, t.ai, t.br, t.bi, t.wr, t.wi, t.sc, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    chk({tag, "_latency"}, lat, 3);
    if (lat != 0) begin
      chk({tag, "_x1r"}, int'(Re_o_1), t.x1r);
      chk({tag, "_x1i"}, int'(Im_o_1), t.x1i);
      chk({tag, "_x2r"}, int'(Re_o_2), t.x2r);
      chk({tag, "_x2i"}, int'(Im_o_2), t.x2i);
      chk({tag, "_ovf"}, int'(ovf), int'(t.sat));
    end
    @(negedge clk);
    chk({tag, "_valid_drop"}, int'(out_valid), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int    got [$];
    int    first, last, wr, wi, ar, ai, br, bi;
    bit    v, sc, model_ovf;
    pend_t p;

    //          ar      ai   br      bi      wr      wi     sc    x1r     x1i  x2r     x2i  sat
    tbl[0]  = '{1000,   0,   500,    0,      16384,  0,     1'b0, 1500,   0,   500,    0,   1'b0};
    tbl[1]  = '{0,      0,   100,    200,    0,      -16384,1'b0, 200,    -100,-200,   100, 1'b0};
    tbl[2]  = '{32000,  0,   32000,  0,      16384,  0,     1'b0, 32767,  0,   0,      0,   1'b1};
    tbl[3]  = '{32000,  0,   32000,  0,      16384,  0,     1'b1, 32000,  0,   0,      0,   1'b0};
    tbl[4]  = '{0,      0,   100,    -50,    -16384, 0,     1'b0, -100,   50,  100,    -50, 1'b0};
    tbl[5]  = '{0,      0,   1,      0,      8192,   0,     1'b0, 1,      0,   -1,     0,   1'b0};
    tbl[6]  = '{7,      7,   -1,     0,      8192,   0,     1'b0, 7,      7,   7,      7,   1'b0};
    tbl[7]  = '{3,      -3,  0,      0,      0,      0,     1'b1, 2,      -1,  2,      -1,  1'b0};
    tbl[8]  = '{-32768, 0,   32767,  0,      16384,  0,     1'b0, -1,     0,   -32768, 0,   1'b1};
    tbl[9]  = '{0,      0,   -32768, -32768, -16384, 16384, 1'b0, 32767,  0,   -32768, 0,   1'b1};
    tbl[10] = '{-5,     9,   -7,     11,     16384,  0,     1'b1, -6,     10,  1,      -1,  1'b0};

    rst_n = 1'b1;
    clr_ovf = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #2;
    chk("rst_x1r", int'(Re_o_1), 0);
    chk("rst_x1i", int'(Im_o_1), 0);
    chk("rst_x2r", int'(Re_o_2), 0);
    chk("rst_x2i", int'(Im_o_2), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_ovf", int'(ovf), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      clear_ovf();
      run_one(tbl[i], $sformatf("vec%0d", i));
    end

    // back-to-back burst, A=0, W=+1.0, B=1..4
    first = -1;
    last = -1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (c < 4) drive(0, 0, c + 1, 0, 16384, 0, 1'b0, 1'b1);
      else in_valid = 1'b0;
      @(negedge clk);
      if (out_valid) begin
        if (first < 0) first = c;
        last = c;
        got.push_back(int'(Re_o_1));
      end
    end
    chk("burst_first", first, 3);
    chk("burst_last", last, 6);
    chk("burst_count", got.size(), 4);
    for (int k = 0; k < got.size() && k < 4; k++) chk($sformatf("burst_x1r%0d", k), got[k], k + 1);

    // saturating operands with in_valid low must not raise ovf or out_valid
    clear_ovf();
    @(posedge clk); #1 drive(32000, 0, 32000, 0, 16384, 0, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("idle_valid", int'(out_valid), 0);
      chk("idle_ovf", int'(ovf), 0);
    end

    // clr_ovf coincident with a saturating output: set wins
    clear_ovf();
    @(posedge clk); #1 drive(32000, 0, 32000, 0, 16384, 0, 1'b0, 1'b1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 clr_ovf = 1'b1;
    @(posedge clk); #1 clr_ovf = 1'b0;
    @(negedge clk);
    chk("setwins_valid", int'(out_valid), 1);
    chk("setwins_ovf", int'(ovf), 1);
    @(negedge clk);
    chk("ovf_sticky", int'(ovf), 1);
    clear_ovf();
    run_one(tbl[2], "presat");

    // async reset with two sets in flight
    @(posedge clk); #1 drive(tbl[10].ar, tbl[10].ai, tbl[10].br, tbl[10].bi, tbl[10].wr, tbl[10].wi, tbl[10].sc, 1'b1);
    @(posedge clk); #1 drive(tbl[0].ar, tbl[0].ai, tbl[0].br, tbl[0].bi, tbl[0].wr, tbl[0].wi, tbl[0].sc, 1'b1);
    @(posedge clk); #1 in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_x1r", int'(Re_o_1), 0);
    chk("midrst_x1i", int'(Im_o_1), 0);
    chk("midrst_x2r", int'(Re_o_2), 0);
    chk("midrst_x2i", int'(Im_o_2), 0);
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_ovf", int'(ovf), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("postrst_valid", int'(out_valid), 0);
    end
    run_one(tbl[10], "after_rst");

    // random stream against the arithmetic model
    clear_ovf();
    model_ovf = 1'b0;
    q.delete();
    for (int n = 0; n < 404; n++) begin
      @(posedge clk); #1;
      v  = (n < 400) && ($urandom_range(0, 3) != 0);
      sc = $urandom_range(0, 1) != 0;
      ar = rnd16();
      ai = rnd16();
      br = rnd16();
      bi = rnd16();
      if ($urandom_range(0, 1) != 0) begin
        ar = ar >>> 4;
        br = br >>> 2;
      end
      case ($urandom_range(0, 3))
        0: begin wr = rnd16(); wi = rnd16(); end
        1: begin wr = ($urandom_range(0, 1) != 0) ? 16384 : -16384; wi = 0; end
        2: begin wr = 0; wi = ($urandom_range(0, 1) != 0) ? 16384 : -16384; end
        default: begin
          wr = int'($urandom_range(0, 32768)) - 16384;
          wi = int'($urandom_range(0, 32768)) - 16384;
        end
      endcase
      drive(ar, ai, br, bi, wr, wi, sc, v);
      p.v = v;
      p.r = model(ar, ai, br, bi, wr, wi, sc);
      q.push_back(p);
      @(negedge clk);
      if (q.size() == 4) begin
        p = q.pop_front();
        chk("rnd_valid", int'(out_valid), int'(p.v));
        if (p.v) begin
          chk("rnd_x1r", int'(Re_o_1), p.r.x1r);
          chk("rnd_x1i", int'(Im_o_1), p.r.x1i);
          chk("rnd_x2r", int'(Re_o_2), p.r.x2r);
          chk("rnd_x2i", int'(Im_o_2), p.r.x2i);
        end
        model_ovf = model_ovf | (p.v & p.r.sat);
        chk("rnd_ovf", int'(ovf), int'(model_ovf));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
